// File: rtl/factorial_engine.sv
// Iterative unsigned factorial unit: one multiply per clock, start/busy/done
// handshake, sticky overflow flag and a result register held between done pulses.
module factorial_engine #(
  parameter int N_W   = 4,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             ovf
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [N_W-1:0]       cnt_q, cnt_d;
  logic [RES_W-1:0]     acc_q, acc_d;
  logic                 ovf_int_q, ovf_int_d;
  logic [RES_W-1:0]     result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic [RES_W+N_W-1:0] prod_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= {N_W{1'b0}};
      acc_q     <= RES_W'(1);
      ovf_int_q <= 1'b0;
      result_q  <= {RES_W{1'b0}};
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_int_q <= ovf_int_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath update; the product is kept wide so the top
  // N_W bits reveal whether the truncated accumulator lost information
  always_comb begin
    prod_s    = (RES_W+N_W)'(acc_q) * (RES_W+N_W)'(cnt_q);
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_int_d = ovf_int_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d     = n;
          acc_d     = RES_W'(1);
          ovf_int_d = 1'b0;
          state_d   = CALC;
        end else begin
          state_d   = IDLE;
        end
      end
      CALC: begin
        if (cnt_q > N_W'(1)) begin
          acc_d     = prod_s[RES_W-1:0];
          ovf_int_d = ovf_int_q | (|prod_s[RES_W+N_W-1:RES_W]);
          cnt_d     = cnt_q - N_W'(1);
        end else begin
          result_d  = acc_q;
          ovf_d     = ovf_int_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy   = (state_q == CALC);
    done   = done_q;
    result = result_q;
    ovf    = ovf_q;
  end

endmodule

// File: tb/tb_factorial_engine.sv
// Directed self-checking bench for factorial_engine (default and small-width builds).
module tb_factorial_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  n;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;

  logic        start2;
  logic [2:0]  n2;
  logic        busy2;
  logic        done2;
  logic [7:0]  result2;
  logic        ovf2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_fact [13] = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720,
                                 32'd5040, 32'd40320, 32'd362880, 32'd3628800,
                                 32'd39916800, 32'd479001600};

  factorial_engine #(.N_W(4), .RES_W(32)) uut (
    .clk(clk), .reset(reset), .start(start), .n(n),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  factorial_engine #(.N_W(3), .RES_W(8)) uut_small (
    .clk(clk), .reset(reset), .start(start2), .n(n2),
    .busy(busy2), .done(done2), .result(result2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then count edges after the accept edge until done (-1 on timeout)
  task automatic do_calc(input logic [3:0] nv, output int lat,
                         output logic [31:0] r, output logic o);
    start = 1'b1;
    n     = nv;
    tick();
    start = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    r = result;
    o = ovf;
  endtask

  task automatic do_calc2(input logic [2:0] nv, output int lat,
                          output logic [7:0] r, output logic o);
    start2 = 1'b1;
    n2     = nv;
    tick();
    start2 = 1'b0;
    lat    = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done2) begin
        lat = i;
        break;
      end
    end
    r = result2;
    o = ovf2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({busy, done, result, ovf} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b result=%0d ovf=%b, expected all 0",
                 i, busy, done, result, ovf);
      end
    end
  endtask

  task automatic test_n5();
    start = 1'b1;
    n     = 4'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL n5_busy step %0d: busy=%b done=%b, expected busy=1 done=0", i, busy, done);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 32'd120 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL n5_done: done=%b busy=%b result=%0d ovf=%b, expected 1 0 120 0",
               done, busy, result, ovf);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || result !== 32'd120) begin
      n_fail++;
      $display("FAIL n5_pulse: done=%b result=%0d, expected done=0 result=120", done, result);
    end
  endtask

  task automatic test_sweep();
    int lat;
    logic [31:0] r;
    logic o;
    for (int i = 0; i <= 12; i++) begin
      do_calc(4'(i), lat, r, o);
      n_checks++;
      if (r !== exp_fact[i] || o !== 1'b0 || lat != ((i < 1) ? 1 : i)) begin
        n_fail++;
        $display("FAIL sweep n=%0d: result=%0d ovf=%b latency=%0d, expected %0d 0 %0d",
                 i, r, o, lat, exp_fact[i], (i < 1) ? 1 : i);
      end
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] r;
    logic o;
    do_calc(4'd13, lat, r, o);
    n_checks++;
    if (r !== 32'd1932053504 || o !== 1'b1 || lat != 13) begin
      n_fail++;
      $display("FAIL ovf_n13: result=%0d ovf=%b lat=%0d, expected 1932053504 1 13", r, o, lat);
    end
    do_calc(4'd15, lat, r, o);
    n_checks++;
    if (r !== 32'd2004310016 || o !== 1'b1 || lat != 15) begin
      n_fail++;
      $display("FAIL ovf_n15: result=%0d ovf=%b lat=%0d, expected 2004310016 1 15", r, o, lat);
    end
    do_calc(4'd3, lat, r, o);
    n_checks++;
    if (r !== 32'd6 || o !== 1'b0 || lat != 3) begin
      n_fail++;
      $display("FAIL ovf_clear_n3: result=%0d ovf=%b lat=%0d, expected 6 0 3", r, o, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] r;
    logic o;
    do_calc(4'd4, lat, r, o);
    n_checks++;
    if (r !== 32'd24 || lat != 4) begin
      n_fail++;
      $display("FAIL b2b_first: result=%0d lat=%0d, expected 24 4", r, lat);
    end
    // still in the done cycle: request the next computation immediately
    start = 1'b1;
    n     = 4'd2;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 32'd24) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b result=%0d, expected 1 0 24", busy, done, result);
    end
    tick();
    tick();
    n_checks++;
    if (done !== 1'b1 || result !== 32'd2 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b result=%0d ovf=%b, expected 1 2 0", done, result, ovf);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int extra;
    start = 1'b1;
    n     = 4'd4;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    n     = 4'd7;
    tick();
    start = 1'b0;
    n     = 4'd9;
    lat   = 2;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      lat++;
    end
    n_checks++;
    if (done !== 1'b1 || lat != 4 || result !== 32'd24) begin
      n_fail++;
      $display("FAIL ignore_start: done=%b lat=%0d result=%0d, expected 1 4 24", done, lat, result);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra != 0 || result !== 32'd24) begin
      n_fail++;
      $display("FAIL ignore_no_extra: active_cycles=%0d result=%0d, expected 0 24", extra, result);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    int dones;
    logic [31:0] r;
    logic o;
    start = 1'b1;
    n     = 4'd10;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, result, ovf} !== 35'd0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b result=%0d ovf=%b, expected all 0",
               busy, done, result, ovf);
    end
    repeat (2) tick();
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones != 0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_no_done: active_cycles=%0d result=%0d, expected 0 0", dones, result);
    end
    do_calc(4'd6, lat, r, o);
    n_checks++;
    if (r !== 32'd720 || o !== 1'b0 || lat != 6) begin
      n_fail++;
      $display("FAIL after_reset_n6: result=%0d ovf=%b lat=%0d, expected 720 0 6", r, o, lat);
    end
  endtask

  task automatic test_small_params();
    int lat;
    logic [7:0] r;
    logic o;
    do_calc2(3'd5, lat, r, o);
    n_checks++;
    if (r !== 8'd120 || o !== 1'b0 || lat != 5) begin
      n_fail++;
      $display("FAIL small_n5: result=%0d ovf=%b lat=%0d, expected 120 0 5", r, o, lat);
    end
    do_calc2(3'd6, lat, r, o);
    n_checks++;
    if (r !== 8'd208 || o !== 1'b1 || lat != 6) begin
      n_fail++;
      $display("FAIL small_n6: result=%0d ovf=%b lat=%0d, expected 208 1 6", r, o, lat);
    end
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    n      = 4'd0;
    start2 = 1'b0;
    n2     = 3'd0;
    test_reset();
    test_n5();
    test_sweep();
    test_overflow();
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
    test_small_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
